// File: rtl/axil_req_arbiter.sv
// ---------------------------------------------------------------------------
// axil_req_arbiter
//   Shares one AXI4-Lite master port between N_REQ local requesters, one
//   transaction at a time, with round-robin arbitration. Each requester
//   raises req (with req_we/req_addr/req_wdata) and holds it until it gets a
//   one-cycle ack pulse. The arbiter then runs either the write sequence
//   (AW+W, then B) or the read sequence (AR, then R) on the master port.
//
// Ports
//   ACLK, ARESET          clock and synchronous active-high reset
//   req/req_we            per-requester request and direction (1 = write)
//   req_addr/req_wdata    packed per-requester address and write data
//   ack                   one-hot completion pulse
//   ack_rdata/ack_resp    read data (0 for writes) and BRESP/RRESP; these
//                         hold until the next completion
//   M_AXI_*               AXI4-Lite master port
// ---------------------------------------------------------------------------
module axil_req_arbiter #(
  parameter int N_REQ            = 2,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ-1:0]                     req_we,
  input  logic [N_REQ*C_AXI_ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ*C_AXI_DATA_WIDTH-1:0]    req_wdata,
  output logic [N_REQ-1:0]                     ack,
  output logic [C_AXI_DATA_WIDTH-1:0]          ack_rdata,
  output logic [1:0]                           ack_resp,
  output logic [C_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                           M_AXI_AWPROT,
  output logic                                 M_AXI_AWVALID,
  input  logic                                 M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
  output logic                                 M_AXI_WVALID,
  input  logic                                 M_AXI_WREADY,
  input  logic [1:0]                           M_AXI_BRESP,
  input  logic                                 M_AXI_BVALID,
  output logic                                 M_AXI_BREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                           M_AXI_ARPROT,
  output logic                                 M_AXI_ARVALID,
  input  logic                                 M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                           M_AXI_RRESP,
  input  logic                                 M_AXI_RVALID,
  output logic                                 M_AXI_RREADY
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, DONE} state_t;

  state_t          stateReg, stateNext;
  logic [PW-1:0]   ptrReg, ptrNext;
  logic [PW-1:0]   grantReg, grantNext;
  logic [AW-1:0]   awAddrReg, awAddrNext;
  logic [AW-1:0]   arAddrReg, arAddrNext;
  logic [DW-1:0]   wDataReg, wDataNext;
  logic            awValidReg, awValidNext;
  logic            wValidReg, wValidNext;
  logic            awDoneReg, awDoneNext;
  logic            wDoneReg, wDoneNext;
  logic            bReadyReg, bReadyNext;
  logic            arValidReg, arValidNext;
  logic            rReadyReg, rReadyNext;
  logic [N_REQ-1:0] ackReg, ackNext;
  logic [DW-1:0]   ackRdataReg, ackRdataNext;
  logic [1:0]      ackRespReg, ackRespNext;

  // Unpacked views of the packed request buses, plus the one-hot form of
  // the latched grant used for the ack pulse.
  logic [AW-1:0]    reqAddrArr  [N_REQ];
  logic [DW-1:0]    reqWdataArr [N_REQ];
  logic [N_REQ-1:0] grantOh;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign reqAddrArr[gi]  = req_addr[gi*AW +: AW];
    assign reqWdataArr[gi] = req_wdata[gi*DW +: DW];
    assign grantOh[gi]     = (grantReg == PW'(gi));
  end

  // Round-robin pick: scan ptr, ptr+1, ... and keep the first hit. The loop
  // runs from the far end back so the nearest requester is the last write.
  logic          anyReq;
  logic [PW-1:0] grantSel;

  always_comb begin
    int idx;
    idx      = 0;
    anyReq   = 1'b0;
    grantSel = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptrReg) + k) % N_REQ;
      if (req[idx]) begin
        anyReq   = 1'b1;
        grantSel = PW'(idx);
      end
    end
  end

  // AW and W complete independently; a handshake on this edge counts too.
  logic awComplete, wComplete;
  assign awComplete = awDoneReg | (awValidReg & M_AXI_AWREADY);
  assign wComplete  = wDoneReg  | (wValidReg  & M_AXI_WREADY);

  // State and output registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stateReg    <= IDLE;
      ptrReg      <= '0;
      grantReg    <= '0;
      awAddrReg   <= '0;
      arAddrReg   <= '0;
      wDataReg    <= '0;
      awValidReg  <= 1'b0;
      wValidReg   <= 1'b0;
      awDoneReg   <= 1'b0;
      wDoneReg    <= 1'b0;
      bReadyReg   <= 1'b0;
      arValidReg  <= 1'b0;
      rReadyReg   <= 1'b0;
      ackReg      <= '0;
      ackRdataReg <= '0;
      ackRespReg  <= '0;
    end else begin
      stateReg    <= stateNext;
      ptrReg      <= ptrNext;
      grantReg    <= grantNext;
      awAddrReg   <= awAddrNext;
      arAddrReg   <= arAddrNext;
      wDataReg    <= wDataNext;
      awValidReg  <= awValidNext;
      wValidReg   <= wValidNext;
      awDoneReg   <= awDoneNext;
      wDoneReg    <= wDoneNext;
      bReadyReg   <= bReadyNext;
      arValidReg  <= arValidNext;
      rReadyReg   <= rReadyNext;
      ackReg      <= ackNext;
      ackRdataReg <= ackRdataNext;
      ackRespReg  <= ackRespNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (anyReq) stateNext = req_we[grantSel] ? WR : RD_A;
      WR:   if (awComplete && wComplete) stateNext = WR_B;
      WR_B: if (M_AXI_BVALID) stateNext = DONE;
      RD_A: if (M_AXI_ARREADY) stateNext = RD_R;
      RD_R: if (M_AXI_RVALID) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output / datapath next values. The ack pulse is loaded on the edge that
  // enters DONE so that it is visible during the DONE cycle itself.
  always_comb begin
    ptrNext      = ptrReg;
    grantNext    = grantReg;
    awAddrNext   = awAddrReg;
    arAddrNext   = arAddrReg;
    wDataNext    = wDataReg;
    awValidNext  = awValidReg;
    wValidNext   = wValidReg;
    awDoneNext   = awDoneReg;
    wDoneNext    = wDoneReg;
    bReadyNext   = bReadyReg;
    arValidNext  = arValidReg;
    rReadyNext   = rReadyReg;
    ackNext      = '0;
    ackRdataNext = ackRdataReg;
    ackRespNext  = ackRespReg;
    case (stateReg)
      IDLE: begin
        if (anyReq) begin
          grantNext  = grantSel;
          awDoneNext = 1'b0;
          wDoneNext  = 1'b0;
          if (req_we[grantSel]) begin
            awAddrNext  = reqAddrArr[grantSel];
            wDataNext   = reqWdataArr[grantSel];
            awValidNext = 1'b1;
            wValidNext  = 1'b1;
          end else begin
            arAddrNext  = reqAddrArr[grantSel];
            arValidNext = 1'b1;
          end
        end
      end
      WR: begin
        if (awValidReg && M_AXI_AWREADY) begin
          awValidNext = 1'b0;
          awDoneNext  = 1'b1;
        end
        if (wValidReg && M_AXI_WREADY) begin
          wValidNext = 1'b0;
          wDoneNext  = 1'b1;
        end
        if (awComplete && wComplete) bReadyNext = 1'b1;
      end
      WR_B: begin
        if (M_AXI_BVALID) begin
          bReadyNext   = 1'b0;
          ackRespNext  = M_AXI_BRESP;
          ackRdataNext = '0;
          ackNext      = grantOh;
        end
      end
      RD_A: begin
        if (M_AXI_ARREADY) begin
          arValidNext = 1'b0;
          rReadyNext  = 1'b1;
        end
      end
      RD_R: begin
        if (M_AXI_RVALID) begin
          rReadyNext   = 1'b0;
          ackRdataNext = M_AXI_RDATA;
          ackRespNext  = M_AXI_RRESP;
          ackNext      = grantOh;
        end
      end
      DONE: begin
        // Next search starts just after the requester that was served.
        ptrNext = (int'(grantReg) == N_REQ - 1) ? '0 : grantReg + 1'b1;
      end
      default: ;
    endcase
  end

  assign ack           = ackReg;
  assign ack_rdata     = ackRdataReg;
  assign ack_resp      = ackRespReg;
  assign M_AXI_AWADDR  = awAddrReg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awValidReg;
  assign M_AXI_WDATA   = wDataReg;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wValidReg;
  assign M_AXI_BREADY  = bReadyReg;
  assign M_AXI_ARADDR  = arAddrReg;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arValidReg;
  assign M_AXI_RREADY  = rReadyReg;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_req_arbiter
//   Directed bench for axil_req_arbiter (N_REQ=2, 32-bit address/data).
//   A small behavioural AXI4-Lite slave (with a 16-word memory, optional
//   WREADY delay, optional B suppression and forced read data/response)
//   answers the master port; a monitor counts VALID cycles and ack pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            tb_ACLK;
  logic            ARESET;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   ack_rdata;
  logic [1:0]      ack_resp;
  logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
  logic            M_AXI_AWVALID, M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA, M_AXI_RDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
  logic            M_AXI_BVALID, M_AXI_BREADY;
  logic            M_AXI_ARVALID, M_AXI_ARREADY;
  logic            M_AXI_RVALID, M_AXI_RREADY;

  axil_req_arbiter #(.N_REQ(N), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .ack_rdata(ack_rdata), .ack_resp(ack_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  // ---------------- slave configuration (written by the stimulus only) ----
  logic          bEnable;
  logic [1:0]    bRespVal, rRespVal;
  logic          rdOverride;
  logic [DW-1:0] rdataOv;
  int            wDelayCfg;

  // ---------------- behavioural slave: decides readies for the next edge --
  logic [DW-1:0] mem [16];
  logic [AW-1:0] awAddrS, rAddrS;
  logic [DW-1:0] wDataS;
  int            wWait;

  initial begin
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_BRESP = 2'b00; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    awAddrS = '0; rAddrS = '0; wDataS = '0; wWait = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge tb_ACLK);
      if (ARESET) begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        wWait = 0;
      end else begin
        M_AXI_AWREADY = 1'b1;
        M_AXI_ARREADY = 1'b1;
        if (!M_AXI_WVALID) wWait = wDelayCfg;
        M_AXI_WREADY = (wWait == 0);
        if (M_AXI_WVALID && wWait > 0) wWait = wWait - 1;
        if (M_AXI_AWVALID && M_AXI_AWREADY) awAddrS = M_AXI_AWADDR;
        if (M_AXI_WVALID && M_AXI_WREADY) wDataS = M_AXI_WDATA;
        M_AXI_BRESP  = bRespVal;
        M_AXI_BVALID = bEnable && M_AXI_BREADY;
        if (M_AXI_BVALID) mem[awAddrS[5:2]] = wDataS;
        if (M_AXI_ARVALID && M_AXI_ARREADY) rAddrS = M_AXI_ARADDR;
        M_AXI_RVALID = M_AXI_RREADY;
        M_AXI_RDATA  = rdOverride ? rdataOv : mem[rAddrS[5:2]];
        M_AXI_RRESP  = rRespVal;
      end
    end
  end

  // ---------------- monitor: samples just after the falling edge ----------
  int   awvCnt, wvCnt, arvCnt, ackCnt, breadyEarly;
  logic wHsSeen;

  initial begin
    awvCnt = 0; wvCnt = 0; arvCnt = 0; ackCnt = 0; breadyEarly = 0; wHsSeen = 1'b0;
    forever begin
      @(negedge tb_ACLK);
      #1;
      if (M_AXI_AWVALID) awvCnt++;
      if (M_AXI_WVALID)  wvCnt++;
      if (M_AXI_ARVALID) arvCnt++;
      if (ack != '0)     ackCnt++;
      if (M_AXI_BREADY && !wHsSeen) breadyEarly++;
      if (M_AXI_WVALID && M_AXI_WREADY) wHsSeen = 1'b1;
      if (ack != '0 || ARESET) wHsSeen = 1'b0;
    end
  end

  // ---------------- checking ----------------------------------------------
  int nCompared = 0;
  int nMismatch = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an ack pulse; lat counts falling edges from the call.
  task automatic waitAck(input string tag, input int budget, output logic [N-1:0] got, output int lat);
    got = '0;
    lat = 0;
    for (int i = 0; i < budget && got == '0; i++) begin
      @(negedge tb_ACLK);
      lat++;
      got = ack;
    end
    $display("txn %s: ack=%b lat=%0d rdata=0x%08h resp=%0d", tag, got, lat, ack_rdata, ack_resp);
    checkVal({tag, "_ack_seen"}, 64'(got != '0), 64'd1);
  endtask

  // ---------------- stimulus ----------------------------------------------
  logic [N-1:0] g1, g2, g3, g4;
  int           l1, l2, l3, l4;
  int           s0, s1, s2, s3;
  logic         seen;

  initial begin
    ARESET = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    bEnable = 1'b1; bRespVal = 2'b00; rRespVal = 2'b00;
    rdOverride = 1'b0; rdataOv = '0; wDelayCfg = 0;
    repeat (3) @(negedge tb_ACLK);

    // Reset state
    checkVal("rst_valid_ready", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    checkVal("rst_ack", ack, 0);
    checkVal("rst_ack_rdata", ack_rdata, 0);
    checkVal("rst_ack_resp", ack_resp, 0);
    checkVal("rst_addrs", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
    checkVal("rst_wdata", M_AXI_WDATA, 0);
    ARESET = 1'b0;

    // 1: minimum-latency write from requester 0
    req_addr[0 +: AW] = 32'h0; req_wdata[0 +: DW] = 32'h0101FFFF;
    req_we = 2'b01; req = 2'b01;
    @(negedge tb_ACLK);
    checkVal("t1_c1_awvalid", M_AXI_AWVALID, 1);
    checkVal("t1_c1_wvalid", M_AXI_WVALID, 1);
    checkVal("t1_c1_arvalid", M_AXI_ARVALID, 0);
    checkVal("t1_c1_awaddr", M_AXI_AWADDR, 32'h0);
    checkVal("t1_c1_wdata", M_AXI_WDATA, 32'h0101FFFF);
    checkVal("t1_c1_wstrb", M_AXI_WSTRB, 4'hF);
    checkVal("t1_c1_prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
    @(negedge tb_ACLK);
    checkVal("t1_c2_valids_low", {M_AXI_AWVALID, M_AXI_WVALID}, 0);
    checkVal("t1_c2_bready", M_AXI_BREADY, 1);
    @(negedge tb_ACLK);
    $display("txn t1: ack=%b rdata=0x%08h resp=%0d", ack, ack_rdata, ack_resp);
    checkVal("t1_c3_ack", ack, 2'b01);
    checkVal("t1_c3_resp", ack_resp, 2'b00);
    checkVal("t1_c3_rdata", ack_rdata, 0);
    checkVal("t1_c3_bready_low", M_AXI_BREADY, 0);
    req = '0;
    @(negedge tb_ACLK);
    checkVal("t1_c4_ack_pulse", ack, 0);

    // 2: read back the word just written
    s0 = arvCnt;
    req_we = 2'b00; req = 2'b01;
    waitAck("t2", 20, g1, l1);
    req = '0;
    checkVal("t2_ack", g1, 2'b01);
    checkVal("t2_latency", l1, 3);
    checkVal("t2_rdata", ack_rdata, 32'h0101FFFF);
    checkVal("t2_resp", ack_resp, 2'b00);
    checkVal("t2_araddr", M_AXI_ARADDR, 32'h0);
    @(negedge tb_ACLK);
    checkVal("t2_arvalid_cycles", arvCnt - s0, 1);

    // 5: read with SLVERR and forced data
    rdOverride = 1'b1; rdataOv = 32'hDEAD0011; rRespVal = 2'b10;
    req_addr[0 +: AW] = 32'h4; req_we = 2'b00; req = 2'b01;
    waitAck("t5", 20, g1, l1);
    req = '0;
    checkVal("t5_ack", g1, 2'b01);
    checkVal("t5_resp", ack_resp, 2'b10);
    checkVal("t5_rdata", ack_rdata, 32'hDEAD0011);
    rdOverride = 1'b0; rRespVal = 2'b00;
    @(negedge tb_ACLK);

    // 4: write with WREADY held off for 3 cycles
    wDelayCfg = 3;
    @(negedge tb_ACLK);
    s0 = awvCnt; s1 = wvCnt; s2 = breadyEarly; s3 = ackCnt;
    req_addr[0 +: AW] = 32'h8; req_wdata[0 +: DW] = 32'h12345678;
    req_we = 2'b01; req = 2'b01;
    waitAck("t4", 30, g1, l1);
    req = '0;
    checkVal("t4_ack", g1, 2'b01);
    checkVal("t4_latency", l1, 6);
    checkVal("t4_rdata_zero", ack_rdata, 0);
    repeat (3) @(negedge tb_ACLK);
    checkVal("t4_awvalid_cycles", awvCnt - s0, 1);
    checkVal("t4_wvalid_cycles", wvCnt - s1, 4);
    checkVal("t4_bready_early", breadyEarly - s2, 0);
    checkVal("t4_ack_count", ackCnt - s3, 1);
    wDelayCfg = 0;

    // 3: round-robin with both requesters after reset
    ARESET = 1'b1; req = '0;
    repeat (2) @(negedge tb_ACLK);
    ARESET = 1'b0;
    req_addr = {32'h14, 32'h10}; req_wdata = {32'hB1B1B1B1, 32'hA0A0A0A0};
    req_we = 2'b11; req = 2'b11;
    waitAck("t3a", 20, g1, l1);
    req = req & ~g1;
    waitAck("t3b", 20, g2, l2);
    req = req & ~g2;
    checkVal("t3_first", g1, 2'b01);
    checkVal("t3_second", g2, 2'b10);
    checkVal("t3_second_wait", l2, 4);
    @(negedge tb_ACLK);
    req = 2'b11;
    waitAck("t3c", 20, g3, l3);
    req = req & ~g3;
    waitAck("t3d", 20, g4, l4);
    req = req & ~g4;
    checkVal("t3_third", g3, 2'b01);
    checkVal("t3_fourth", g4, 2'b10);
    @(negedge tb_ACLK);

    // 6: reset while waiting for B, then a clean write from requester 1
    bEnable = 1'b0;
    req_addr[0 +: AW] = 32'h18; req_we = 2'b01; req = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge tb_ACLK);
      seen = M_AXI_BREADY;
    end
    checkVal("t6_in_wr_b", seen, 1);
    s0 = ackCnt;
    ARESET = 1'b1; req = '0;
    @(negedge tb_ACLK);
    checkVal("t6_valid_ready_cleared", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    checkVal("t6_no_ack", ack, 0);
    ARESET = 1'b0; bEnable = 1'b1; bRespVal = 2'b11;
    repeat (3) @(negedge tb_ACLK);
    checkVal("t6_dropped_no_ack", ackCnt - s0, 0);
    req_addr[AW +: AW] = 32'h1C; req_wdata[DW +: DW] = 32'hC0FFEE00;
    req_we = 2'b10; req = 2'b10;
    waitAck("t6", 20, g1, l1);
    req = '0;
    checkVal("t6_ack", g1, 2'b10);
    checkVal("t6_latency", l1, 3);
    checkVal("t6_resp_decerr", ack_resp, 2'b11);
    checkVal("t6_rdata_zero", ack_rdata, 0);
    repeat (2) @(negedge tb_ACLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
